// File: rtl/button_led_ctrl.sv
// button_led_ctrl
//   Sits between the raw iCEBreaker user button and LEDR. The button is
//   synchronised and debounced. Each clean press becomes a one-cycle event,
//   and that event steps LEDR through OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF.
//
//   Optional feature: define LONG_PRESS_EN to enable long-press detection.
//   A debounced hold of LONG_PRESS_CYCLES forces the mode back to OFF and
//   emits one long_press pulse. Without the macro, long_press is tied low.
module button_led_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int BLINK_SLOW_CYCLES = 6000000,
    parameter int BLINK_FAST_CYCLES = 1500000,
    parameter int LONG_PRESS_CYCLES = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic       LEDR,
    output logic [1:0] mode,
    output logic       press_pulse,
    output logic       long_press
);

    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_ON   = 2'd1;
    localparam logic [1:0] MODE_SLOW = 2'd2;
    localparam logic [1:0] MODE_FAST = 2'd3;

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1 (parameter is >= 2).
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    // One blink counter serves both rates, so size it for the longer half-period.
    localparam int BMAX = (BLINK_SLOW_CYCLES > BLINK_FAST_CYCLES) ? BLINK_SLOW_CYCLES
                                                                  : BLINK_FAST_CYCLES;
    localparam int BW = (BMAX > 1) ? $clog2(BMAX) : 1;
    localparam logic [BW-1:0] SLOW_LAST = BW'(BLINK_SLOW_CYCLES - 1);
    localparam logic [BW-1:0] FAST_LAST = BW'(BLINK_FAST_CYCLES - 1);

    logic          s1_r;
    logic          s2_r;
    logic          db_r;
    logic          db_q_r;
    logic [DW-1:0] db_cnt_r;
    logic [BW-1:0] bcnt_r;
    logic          phase_r;

    logic          press_rise_s;
    logic          long_hit_s;
    logic [1:0]    mode_nxt_s;
    logic          mode_chg_s;
    logic [BW-1:0] half_last_s;
    logic [BW-1:0] bcnt_nxt_s;
    logic          phase_nxt_s;
    logic          led_nxt_s;

    // Two-flop synchroniser for the asynchronous button level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= button;
            s2_r <= s1_r;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_r     <= 1'b0;
            db_cnt_r <= '0;
        end else if (s2_r == db_r) begin
            db_cnt_r <= '0;
        end else if (db_cnt_r == DB_LAST) begin
            db_r     <= s2_r;
            db_cnt_r <= '0;
        end else begin
            db_cnt_r <= db_cnt_r + DW'(1);
        end
    end

    assign press_rise_s = db_r & ~db_q_r;

`ifdef LONG_PRESS_EN
    localparam int HW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] hcnt_r;
    logic          lp_done_r;

    // The hold counter stops at its terminal value. lp_done_r keeps the hit to a single pulse per hold.
    assign long_hit_s = db_r & (hcnt_r == H_LAST) & ~lp_done_r;

    // Hold-time counter: runs while the debounced level is high and clears on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_r    <= '0;
            lp_done_r <= 1'b0;
        end else if (!db_r) begin
            hcnt_r    <= '0;
            lp_done_r <= 1'b0;
        end else if (hcnt_r != H_LAST) begin
            hcnt_r <= hcnt_r + HW'(1);
        end else if (long_hit_s) begin
            lp_done_r <= 1'b1;
        end else begin
            hcnt_r <= hcnt_r;
        end
    end

    // Registered long-press event pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_press <= 1'b0;
        end else begin
            long_press <= long_hit_s;
        end
    end
`else
    // Only referenced so the hold-time parameter is not flagged as unused in this build.
    logic lp_cfg_unused_s;
    assign lp_cfg_unused_s = ^(32'(LONG_PRESS_CYCLES));
    assign long_hit_s      = 1'b0;
    assign long_press      = 1'b0;
`endif

    // Next mode: a long press overrides everything, otherwise a press steps the mode with wrap.
    always_comb begin
        mode_nxt_s = mode;
        mode_chg_s = 1'b0;
        if (long_hit_s) begin
            mode_nxt_s = MODE_OFF;
            mode_chg_s = 1'b1;
        end else if (press_rise_s) begin
            mode_nxt_s = mode + 2'd1;
            mode_chg_s = 1'b1;
        end else begin
            mode_nxt_s = mode;
            mode_chg_s = 1'b0;
        end
    end

    // Blink timebase: any mode entry restarts the count with the phase lit.
    always_comb begin
        half_last_s = (mode == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
        bcnt_nxt_s  = bcnt_r;
        phase_nxt_s = phase_r;
        if (mode_chg_s) begin
            bcnt_nxt_s  = '0;
            phase_nxt_s = 1'b1;
        end else if (mode[1]) begin
            if (bcnt_r == half_last_s) begin
                bcnt_nxt_s  = '0;
                phase_nxt_s = ~phase_r;
            end else begin
                bcnt_nxt_s  = bcnt_r + BW'(1);
                phase_nxt_s = phase_r;
            end
        end else begin
            bcnt_nxt_s  = '0;
            phase_nxt_s = phase_r;
        end
    end

    // LED value for the mode that will be current after this edge.
    always_comb begin
        led_nxt_s = 1'b0;
        case (mode_nxt_s)
            MODE_OFF:  led_nxt_s = 1'b0;
            MODE_ON:   led_nxt_s = 1'b1;
            MODE_SLOW: led_nxt_s = phase_nxt_s;
            MODE_FAST: led_nxt_s = phase_nxt_s;
            default:   led_nxt_s = 1'b0;
        endcase
    end

    // Press edge detect, mode register, blink state and the registered LED drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q_r      <= 1'b0;
            press_pulse <= 1'b0;
            mode        <= MODE_OFF;
            LEDR        <= 1'b0;
            bcnt_r      <= '0;
            phase_r     <= 1'b0;
        end else begin
            db_q_r      <= db_r;
            press_pulse <= press_rise_s;
            mode        <= mode_nxt_s;
            LEDR        <= led_nxt_s;
            bcnt_r      <= bcnt_nxt_s;
            phase_r     <= phase_nxt_s;
        end
    end

endmodule

// File: tb/tb_button_led_ctrl.sv
// Scoreboard bench for button_led_ctrl with short timing parameters.
// Stimulus pushes the expected press / long-press events into queues.
// A negedge monitor pops and compares them whenever the DUT pulses.
module tb_button_led_ctrl;

    localparam int DEB  = 4;
    localparam int SLOW = 8;
    localparam int FAST = 2;
    localparam int LONG = 20;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       button = 1'b1;
    logic       LEDR;
    logic [1:0] mode;
    logic       press_pulse;
    logic       long_press;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
        logic       led;
    } exp_t;

    exp_t       sb_q[$];
    int         lp_q[$];
    exp_t       mon_e;
    int         mon_lp;
    logic [1:0] exp_mode = 2'd0;

    button_led_ctrl #(
        .DEBOUNCE_CYCLES  (DEB),
        .BLINK_SLOW_CYCLES(SLOW),
        .BLINK_FAST_CYCLES(FAST),
        .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .LEDR       (LEDR),
        .mode       (mode),
        .press_pulse(press_pulse),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge k it holds k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT event against the front of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (press_pulse) begin
                if (sb_q.size() == 0) begin
                    check("unexpected press_pulse", int'(press_pulse), 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("press_pulse cycle", cyc, mon_e.cyc);
                    check("mode at press", int'(mode), int'(mon_e.mode));
                    check("LEDR at press", int'(LEDR), int'(mon_e.led));
                end
            end
`ifdef LONG_PRESS_EN
            if (long_press) begin
                if (lp_q.size() == 0) begin
                    check("unexpected long_press", int'(long_press), 0);
                end else begin
                    mon_lp = lp_q.pop_front();
                    check("long_press cycle", cyc, mon_lp);
                    check("mode at long_press", int'(mode), 0);
                    check("LEDR at long_press", int'(LEDR), 0);
                end
            end
`else
            check("long_press tied low", int'(long_press), 0);
`endif
        end
    end

    // Press: button rises just after edge t, so the pulse is expected on edge t+7.
    task automatic press(input int hold, output int pulse_edge);
        exp_t e;
        @(posedge clk);
        #1;
        button   = 1'b1;
        exp_mode = exp_mode + 2'd1;
        e.cyc    = cyc + 7;
        e.mode   = exp_mode;
        e.led    = (exp_mode != 2'd0);
        sb_q.push_back(e);
        pulse_edge = cyc + 7;
        repeat (hold) @(posedge clk);
        #1;
        button = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic check_blink(input int pe, input int half, input int n, input string name);
        repeat (n) begin
            @(negedge clk);
            check(name, int'(LEDR), ((((cyc - pe) / half) % 2) == 0) ? 1 : 0);
        end
    endtask

    initial begin
        int r;
        int pe;
        int t;
        exp_t e;

        // Reset held with the button already pressed.
        rst    = 1'b1;
        button = 1'b1;
        repeat (3) @(negedge clk);
        check("reset LEDR", int'(LEDR), 0);
        check("reset mode", int'(mode), 0);
        check("reset press_pulse", int'(press_pulse), 0);
        check("reset long_press", int'(long_press), 0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        r   = cyc;
        exp_mode = 2'd1;
        e.cyc  = r + 7;
        e.mode = 2'd1;
        e.led  = 1'b1;
        sb_q.push_back(e);
        repeat (7) @(negedge clk);
        check("mode before debounce settles", int'(mode), 0);
        check("LEDR before debounce settles", int'(LEDR), 0);
        repeat (4) @(posedge clk);
        #1;
        button = 1'b0;
        repeat (12) @(posedge clk);

        // Glitch of 3 cycles: must be dropped.
        @(posedge clk);
        #1;
        button = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        button = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("mode after glitch", int'(mode), int'(exp_mode));

        // ON -> BLINK_SLOW -> BLINK_FAST -> OFF -> ON -> BLINK_SLOW.
        press(8, pe);
        check_blink(pe, SLOW, 24, "slow blink LEDR");
        press(8, pe);
        check_blink(pe, FAST, 12, "fast blink LEDR");
        press(8, pe);
        @(negedge clk);
        check("LEDR in OFF", int'(LEDR), 0);
        press(8, pe);
        @(negedge clk);
        check("LEDR in ON", int'(LEDR), 1);
        press(8, pe);

        // Reset in the middle of a lit slow-blink phase.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if ((cyc - pe) >= 2 * SLOW && (((cyc - pe) / SLOW) % 2) == 0) break;
        end
        check("LEDR lit before async reset", int'(LEDR), 1);
        rst = 1'b1;
        #1;
        check("async reset LEDR", int'(LEDR), 0);
        check("async reset mode", int'(mode), 0);
        exp_mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Four clean presses: 1, 2, 3, 0.
        for (int k = 0; k < 4; k++) begin
            press(8, pe);
        end
        @(negedge clk);
        check("mode after four presses", int'(mode), 0);

`ifdef LONG_PRESS_EN
        press(8, pe);
        @(posedge clk);
        #1;
        t        = cyc;
        button   = 1'b1;
        exp_mode = 2'd2;
        e.cyc    = t + 7;
        e.mode   = 2'd2;
        e.led    = 1'b1;
        sb_q.push_back(e);
        lp_q.push_back(t + 26);
        repeat (30) @(posedge clk);
        #1;
        button   = 1'b0;
        exp_mode = 2'd0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("mode after long press", int'(mode), 0);
        check("LEDR after long press", int'(LEDR), 0);
        check("pending long_press events", lp_q.size(), 0);
`else
        t = 0;
`endif

        repeat (20) @(negedge clk);
        check("pending press events", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
